// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8-bit UART transmitter between NREQ byte sources.
// Drives a clean ena rising edge per byte and tracks the transmitter's sent flag to completion.
module uart_tx_arbiter #(
   parameter int NREQ      = 2,
   parameter int GW        = 1,
   parameter int LAUNCH_TO = 32,
   parameter int FRAME_TO  = 255
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ*8-1:0]    req_data,
   output logic [NREQ-1:0]      req_ack,
   output logic [NREQ-1:0]      req_done,
   output logic [7:0]           tx_data,
   output logic                 tx_ena,
   input  logic                 tx_sent,
   output logic                 busy,
   output logic [GW-1:0]        cur_grant,
   output logic                 err,
   input  logic                 err_clr
);

   localparam int CMAX = (FRAME_TO > LAUNCH_TO) ? FRAME_TO : LAUNCH_TO;
   localparam int CW   = $clog2(CMAX + 1);
   localparam logic [CW-1:0] FRAME_LIM  = CW'(FRAME_TO - 1);
   localparam logic [CW-1:0] LAUNCH_LIM = CW'(LAUNCH_TO - 1);
   localparam logic [GW-1:0] GRANT_RST  = GW'(NREQ - 1);

   typedef enum logic [2:0] {
      ST_SYNC   = 3'd0,
      ST_IDLE   = 3'd1,
      ST_LAUNCH = 3'd2,
      ST_WAIT   = 3'd3,
      ST_GAP    = 3'd4
   } state_t;

   state_t          state_r, state_s;
   logic [CW-1:0]   cnt_r, cnt_s;
   logic [NREQ-1:0] req_ack_r, req_ack_s;
   logic [NREQ-1:0] req_done_r, req_done_s;
   logic [7:0]      tx_data_r, tx_data_s;
   logic            tx_ena_r, tx_ena_s;
   logic            busy_r;
   logic [GW-1:0]   cur_grant_r, cur_grant_s;
   logic            err_r, err_s, err_set_s;

   logic            sel_found_s;
   logic [GW-1:0]   sel_idx_s;
   logic [7:0]      sel_data_s;
   int              scan_idx_s;

   function automatic logic [NREQ-1:0] grant_onehot(input logic [GW-1:0] idx);
      logic [NREQ-1:0] one_v;
      one_v = {{(NREQ-1){1'b0}}, 1'b1};
      return one_v << idx;
   endfunction

   // Round-robin pick: first pending requester after the last grant, wrapping.
   always_comb begin
      sel_found_s = 1'b0;
      sel_idx_s   = cur_grant_r;
      sel_data_s  = 8'h00;
      scan_idx_s  = 0;
      for (int off = 1; off <= NREQ; off++) begin
         scan_idx_s = (int'(cur_grant_r) + off) % NREQ;
         if (!sel_found_s && req_valid[scan_idx_s]) begin
            sel_found_s = 1'b1;
            sel_idx_s   = GW'(scan_idx_s);
            sel_data_s  = req_data[scan_idx_s*8 +: 8];
         end else begin
            sel_found_s = sel_found_s;
         end
      end
   end

   // Next-state and next-output decode; every output is registered below.
   always_comb begin
      state_s     = state_r;
      cnt_s       = cnt_r;
      req_ack_s   = '0;
      req_done_s  = '0;
      tx_data_s   = tx_data_r;
      tx_ena_s    = 1'b0;
      cur_grant_s = cur_grant_r;
      err_set_s   = 1'b0;
      case (state_r)
         ST_SYNC: begin
            // Transmitter has no reset; let any frame in flight drain first.
            if (tx_sent || (cnt_r == FRAME_LIM)) begin
               state_s = ST_IDLE;
               cnt_s   = '0;
            end else begin
               cnt_s = cnt_r + CW'(1);
            end
         end
         ST_IDLE: begin
            if (sel_found_s) begin
               state_s     = ST_LAUNCH;
               cnt_s       = '0;
               tx_data_s   = sel_data_s;
               cur_grant_s = sel_idx_s;
               req_ack_s   = grant_onehot(sel_idx_s);
               tx_ena_s    = 1'b1;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_LAUNCH: begin
            if (!tx_sent) begin
               state_s = ST_WAIT;
               cnt_s   = '0;
            end else if (cnt_r == LAUNCH_LIM) begin
               state_s    = ST_GAP;
               cnt_s      = '0;
               err_set_s  = 1'b1;
               req_done_s = grant_onehot(cur_grant_r);
            end else begin
               tx_ena_s = 1'b1;
               cnt_s    = cnt_r + CW'(1);
            end
         end
         ST_WAIT: begin
            if (tx_sent) begin
               state_s    = ST_GAP;
               cnt_s      = '0;
               req_done_s = grant_onehot(cur_grant_r);
            end else if (cnt_r == FRAME_LIM) begin
               state_s    = ST_GAP;
               cnt_s      = '0;
               err_set_s  = 1'b1;
               req_done_s = grant_onehot(cur_grant_r);
            end else begin
               cnt_s = cnt_r + CW'(1);
            end
         end
         ST_GAP: begin
            state_s = ST_IDLE;
            cnt_s   = '0;
         end
         default: begin
            state_s = ST_SYNC;
            cnt_s   = '0;
         end
      endcase
      if (err_set_s) begin
         err_s = 1'b1;
      end else if (err_clr) begin
         err_s = 1'b0;
      end else begin
         err_s = err_r;
      end
   end

   // State, counter and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_SYNC;
         cnt_r       <= '0;
         req_ack_r   <= '0;
         req_done_r  <= '0;
         tx_data_r   <= 8'h00;
         tx_ena_r    <= 1'b0;
         busy_r      <= 1'b1;
         cur_grant_r <= GRANT_RST;
         err_r       <= 1'b0;
      end else begin
         state_r     <= state_s;
         cnt_r       <= cnt_s;
         req_ack_r   <= req_ack_s;
         req_done_r  <= req_done_s;
         tx_data_r   <= tx_data_s;
         tx_ena_r    <= tx_ena_s;
         busy_r      <= (state_s != ST_IDLE);
         cur_grant_r <= cur_grant_s;
         err_r       <= err_s;
      end
   end

   assign req_ack   = req_ack_r;
   assign req_done  = req_done_r;
   assign tx_data   = tx_data_r;
   assign tx_ena    = tx_ena_r;
   assign busy      = busy_r;
   assign cur_grant = cur_grant_r;
   assign err       = err_r;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single 8-bit UART transmitter between NREQ byte sources (e.g. keyboard echo, status/message generator) using round-robin arbitration.
- Latches the granted byte and produces a clean rising edge on the transmitter's ena input.
- Tracks the transmitter's sent flag through launch and completion, and reports per-requester ack/done pulses and a sticky timeout error.
- Same clock domain as the transmitter: the 16x-baud tick clock.

Parameters:
- NREQ, 2, number of requesters (2..8).
- GW, 1, width of grant index; must be ≥ ceil(log2(NREQ)), minimum 1.
- LAUNCH_TO, 32, max cycles in LAUNCH waiting for tx_sent to fall.
- FRAME_TO, 255, max cycles in WAIT_DONE or SYNC waiting for tx_sent to rise; must exceed 152.

Ports:
- clk  in  1  tick clock shared with transmitter.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  requester i has a byte pending; held until req_ack[i].
- req_data  in  NREQ*8  byte of requester i at bits [8i+7:8i].
- req_ack  out  NREQ  one-cycle pulse: byte of requester i latched; requester may drop or change its data.
- req_done  out  NREQ  one-cycle pulse: frame for requester i completed or aborted.
- tx_data  out  8  byte to transmitter data_transmit; registered.
- tx_ena  out  1  to transmitter ena.
- tx_sent  in  1  from transmitter sent.
- busy  out  1  high in every state except IDLE.
- cur_grant  out  GW  index of the last granted requester.
- err  out  1  sticky timeout flag.
- err_clr  in  1  clears err; set wins on same-cycle collision.

Behaviour:
- Reset values: req_ack=0, req_done=0, tx_data=0, tx_ena=0, busy=1, cur_grant=NREQ-1, err=0, cycle counter=0. The FSM enters SYNC.
- All outputs are registered.
- States: SYNC, IDLE, LAUNCH, WAIT_DONE, GAP.
- SYNC: tx_ena=0. The transmitter has no reset and may be mid-frame, so the FSM waits here.
  - Go to IDLE when tx_sent==1 or the counter reaches FRAME_TO.
  - No error is raised in SYNC.
- IDLE: if any req_valid, select the first set bit scanning cur_grant+1, cur_grant+2, … modulo NREQ.
  - Latch that requester's byte into tx_data.
  - Set cur_grant to the selected index.
  - Pulse req_ack[sel] on the next cycle and go to LAUNCH.
  - With no request pending, stay in IDLE.
- Grant latency: 1 cycle from req_valid high (in IDLE) to req_ack high. tx_ena rises in the same cycle as req_ack.
- LAUNCH: tx_ena=1 and the counter increments.
  - When tx_sent==0 (transmitter accepted), drop tx_ena, clear the counter and go to WAIT_DONE.
  - If the counter reaches LAUNCH_TO, set err, pulse req_done[cur_grant] and go to GAP.
- WAIT_DONE: tx_ena=0.
  - When tx_sent==1, pulse req_done[cur_grant] and go to GAP.
  - If the counter reaches FRAME_TO, set err, pulse req_done and go to GAP.
- GAP: exactly 1 cycle with tx_ena=0, guaranteeing a fresh rising edge for the next launch; then go to IDLE.
- tx_data stays stable from latch until leaving WAIT_DONE.
- At most one req_ack and one req_done bit are high in any cycle.
- req_valid deasserting after its ack has no effect. A requester not yet granted must keep req_valid high.
- A requester re-requesting immediately after its own req_done is served only after every other pending requester (fairness).
- Single requester pending continuously: back-to-back frames with at most 4 cycles between req_done and the next req_ack (GAP, IDLE, latch).
- Reset asserted mid-frame:
  - tx_ena drops asynchronously and the FSM returns to SYNC.
  - No req_done is issued for the aborted byte; the requester must resend.
- err_clr: clears err on the next edge unless a timeout sets err in the same cycle.

Test Plan:
- Reset release, tx_sent held 1 → SYNC exits to IDLE on the next cycle. With tx_sent held 0 → IDLE after 255 cycles, err stays 0.
- req_valid=2'b01, data0=8'h41; transmitter model drops sent 1 cycle after the ena edge and raises it 152 cycles later → req_ack=01 after 1 cycle, tx_data=8'h41, tx_ena high 2 cycles, then one req_done=01 pulse; err=0.
- Both requesters valid continuously with data0=8'h11, data1=8'h22 → grants alternate 0,1,0,1. tx_data sequence 11,22,11,22; tx_ena low ≥1 cycle between launches.
- tx_sent stuck at 1 after launch → LAUNCH times out after 32 cycles: err=1 and req_done pulse. Then err_clr=1 → err=0 next cycle.
- tx_sent never rises after falling → err=1 after 255 cycles in WAIT_DONE; the next pending requester is still served afterwards.
- rst_n pulsed low in WAIT_DONE → tx_ena=0 immediately, busy=1, state SYNC, no req_done. The next request is served after the transmitter's sent rises.
